input_port: RTL and testbench

- Memory-mapped input peripheral for the SAP-2 computer; the read-side counterpart of the OUT register path.
- An external producer hands a byte over an asynchronous 4-phase req/ack handshake.
- The block synchronizes the handshake, latches the byte into a holding register and raises a ready flag.
- The CPU control unit consumes the byte with a one-cycle read strobe (IN/INM instruction execute step), which clears the flag and releases the producer.

---
 rtl/arch_defs_pkg.sv | 13 +
 rtl/input_port_if.sv | 26 ++
 rtl/sync_ff.sv | 24 ++
 rtl/input_port.sv | 99 +++++++++
 tb/tb_input_port.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture definitions: data width and input-port FSM encoding.
package arch_defs_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int IN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_HOLD,
    IN_RELEASE
  } in_state_t;

endpackage : arch_defs_pkg

// File: rtl/input_port_if.sv
// Producer handshake and CPU-side signals of the SAP-2 input port.
interface input_port_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] ext_data;
  logic                  ext_req;
  logic                  ext_ack;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_ready;
  logic                  overrun;

  // Port-side view: the input_port block itself.
  modport slave (
    input  ext_data, ext_req, rd_en,
    output ext_ack, data_out, data_ready, overrun
  );

  // Environment view: producer plus control unit / bus mux.
  modport master (
    output ext_data, ext_req, rd_en,
    input  ext_ack, data_out, data_ready, overrun
  );

endinterface : input_port_if

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous inputs, async active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/input_port.sv
// SAP-2 memory-mapped input port: synchronized 4-phase req/ack capture into a
// holding register, consumed by a one-cycle CPU read strobe.
module input_port
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH  = arch_defs_pkg::DATA_WIDTH,
  parameter int SYNC_STAGES = IN_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset,
  input_port_if.slave  bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("input_port: SYNC_STAGES must be in 2..4");
  end

  in_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  overrun_q, overrun_d;
  logic                  req_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (bus.ext_req),
    .q     (req_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IN_IDLE;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    ready_d   = ready_q;
    ack_d     = ack_q;
    overrun_d = overrun_q;

    // A read only ever clears the flag; the byte stays visible on data_out.
    if (bus.rd_en) begin
      ready_d = 1'b0;
    end

    unique case (state_q)
      IN_IDLE: begin
        ack_d = 1'b0;
        if (req_s && !ready_q) begin
          data_d  = bus.ext_data;
          ready_d = 1'b1;
          ack_d   = 1'b1;
          state_d = IN_HOLD;
        end else if (req_s) begin
          // Unread byte still held: withhold ack so the producer stalls.
          overrun_d = 1'b1;
        end
      end
      IN_HOLD: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IN_RELEASE;
        end
      end
      IN_RELEASE: begin
        ack_d   = 1'b0;
        state_d = IN_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IN_IDLE;
      end
    endcase
  end

  assign bus.ext_ack    = ack_q;
  assign bus.data_out   = data_q;
  assign bus.data_ready = ready_q;
  assign bus.overrun    = overrun_q;

endmodule : input_port

// File: tb/tb_input_port.sv
// Scoreboard bench for input_port: stimulus queues expected captures, a monitor
// checks each ack rising edge; directed checks cover reset, latency and reads.
module tb_input_port;
  import arch_defs_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  input_port_if #(.DATA_WIDTH(8)) bus ();

  input_port #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every fresh acknowledge means a capture just happened.
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (reset && bus.ext_ack && !ack_prev) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_capture", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data_out", bus.data_out, e.data);
        check("sb_overrun", bus.overrun, e.ovr);
        check("sb_data_ready", bus.data_ready, 1);
      end
    end
    ack_prev <= bus.ext_ack;
  end

  task automatic wait_ack(input logic level, output int lat);
    lat = 0;
    while (bus.ext_ack !== level && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic raise(input logic [7:0] d, input logic ovr, input int exp_lat);
    int lat;
    sb.push_back('{data: d, ovr: ovr});
    @(negedge clk);
    bus.ext_data = d;
    bus.ext_req  = 1'b1;
    wait_ack(1'b1, lat);
    check("ack_rise_latency", lat, exp_lat);
  endtask

  task automatic lower();
    int lat;
    @(negedge clk);
    bus.ext_req = 1'b0;
    wait_ack(1'b0, lat);
    check("ack_fall_latency", lat, 3);
    repeat (2) @(posedge clk);
  endtask

  task automatic read_byte(input logic [7:0] exp_data);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check("read_clears_ready", bus.data_ready, 0);
    check("read_keeps_data", bus.data_out, exp_data);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    bus.ext_data = 8'hFF;
    bus.ext_req  = 1'b1;
    bus.rd_en    = 1'b0;
    reset        = 1'b0;

    // Reset held with an active request: nothing may be captured.
    repeat (4) @(posedge clk);
    #1;
    check("reset_data_out", bus.data_out, 8'h00);
    check("reset_data_ready", bus.data_ready, 0);
    check("reset_ext_ack", bus.ext_ack, 0);
    check("reset_overrun", bus.overrun, 0);

    sb.push_back('{data: 8'hFF, ovr: 1'b0});
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_ack", bus.ext_ack, 1);
    check("post_reset_ready", bus.data_ready, 1);
    lower();
    read_byte(8'hFF);

    // Read with nothing pending is harmless.
    read_byte(8'hFF);
    check("idle_read_no_overrun", bus.overrun, 0);

    // Single transfer.
    raise(8'h0A, 1'b0, 3);
    lower();
    check("single_ready_after_release", bus.data_ready, 1);
    read_byte(8'h0A);

    // Back-to-back transfers, each read before the next request.
    for (int i = 1; i <= 3; i++) begin
      raise(8'(i), 1'b0, 3);
      lower();
      read_byte(8'(i));
    end
    check("b2b_no_overrun", bus.overrun, 0);

    // Backpressure: second request while first byte is unread.
    raise(8'h11, 1'b0, 3);
    lower();
    sb.push_back('{data: 8'h22, ovr: 1'b1});
    @(negedge clk);
    bus.ext_data = 8'h22;
    bus.ext_req  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("bp_ack_low", bus.ext_ack, 0);
    check("bp_overrun", bus.overrun, 1);
    check("bp_data_held", bus.data_out, 8'h11);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    wait_ack(1'b1, lat);
    check("bp_capture_after_read", lat, 1);
    check("bp_overrun_sticky", bus.overrun, 1);
    lower();
    read_byte(8'h22);

    // Reset in HOLD drops ack without waiting for a clock edge.
    raise(8'h5A, 1'b1, 3);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_ack", bus.ext_ack, 0);
    check("midreset_ready", bus.data_ready, 0);
    check("midreset_data", bus.data_out, 8'h00);
    check("midreset_overrun", bus.overrun, 0);
    bus.ext_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_midreset_idle_ack", bus.ext_ack, 0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_input_port
